// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared state encoding and default counter width for pulse_meter.
package pulse_meter_pkg;
  localparam int DEF_CW = 8;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MEAS = 1'b1;
  typedef enum logic {S_IDLE = ST_IDLE, S_MEAS = ST_MEAS} state_e;
endpackage

// File: rtl/pulse_meter_if.sv
// pulse_meter_if: control input, pulse input and measurement results of pulse_meter.
interface pulse_meter_if #(parameter int CW = 8);
  logic          en;
  logic          x;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          match;
  logic          locked;
  logic          timeout;
  modport master (output en, x, input period, high_time, meas_valid, match, locked, timeout);
  modport slave  (input en, x, output period, high_time, meas_valid, match, locked, timeout);
endinterface

// File: rtl/pulse_meter_edge.sv
// edge_sync: synchronizes the asynchronous pulse input and detects its rising edge.
module edge_sync
  import pulse_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic xs,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   xd_q, xd_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], x};
    xd_d   = xs;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      xd_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      xd_q   <= xd_d;
    end
  end
  assign xs   = sync_q[SYNC_STAGES-1];
  assign rise = xs & ~xd_q;
endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures period and high time of a pulse train in clk cycles,
// checks them against an expected ratio and flags loss of pulses.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CW          = DEF_CW,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_PERIOD  = 5,
  parameter int EXP_HIGH    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  pulse_meter_if.slave bus
);
  localparam logic [CW-1:0] CNT_MAX = '1;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CW-1:0] period_q, period_d, high_q, high_d;
  logic          mv_q, mv_d, match_q, match_d, locked_q, locked_d, tmo_q, tmo_d;
  logic          xs, rise;
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (bus.x),
    .xs   (xs),
    .rise (rise)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    match_d  = match_q;
    locked_d = locked_q;
    tmo_d    = tmo_q;
    if (!bus.en) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      locked_d = 1'b0;
      tmo_d    = 1'b0;
    end else if (state_q == S_IDLE) begin
      state_d = rise ? S_MEAS : S_IDLE;
      cnt_d   = rise ? CW'(1) : '0;
      hcnt_d  = rise ? CW'(1) : '0;
    end else if (rise) begin
      period_d = cnt_q;
      high_d   = hcnt_q;
      mv_d     = 1'b1;
      match_d  = (cnt_q == CW'(EXP_PERIOD)) && (hcnt_q == CW'(EXP_HIGH));
      locked_d = 1'b1;
      tmo_d    = 1'b0;
      cnt_d    = CW'(1);
      hcnt_d   = CW'(1);
    end else if (cnt_q == CNT_MAX) begin
      // no edge within the full counter range: give up and wait for a fresh rise
      state_d  = S_IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      locked_d = 1'b0;
      tmo_d    = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      hcnt_d = hcnt_q + CW'(xs);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      match_q  <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
    end
  end
  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = mv_q;
  assign bus.match      = match_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = tmo_q;
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: randomized pulse patterns against a timestamp-based reference
// model, plus literal expectations for the characteristic patterns.
module tb_pulse_meter;
  localparam int CW   = 4;
  localparam int SYNC = 2;
  localparam int MAXC = (1 << CW) - 1;
  localparam int EXPP = 5;
  localparam int EXPH = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mv_seen = 0;
  pulse_meter_if #(.CW(CW)) bus ();
  pulse_meter #(.CW(CW), .SYNC_STAGES(SYNC), .EXP_PERIOD(EXPP), .EXP_HIGH(EXPH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  // reference model: remembers when the current window started and accumulates high samples
  bit xhist[$];
  bit xd_m = 1'b0;
  bit meas = 1'b0;
  int cyc = 0, start = 0, hi = 0;
  int m_period = 0, m_high = 0;
  bit m_mv = 1'b0, m_match = 1'b0, m_locked = 1'b0, m_tmo = 1'b0;
  bit xs_m, rise_m;
  initial begin
    for (int i = 0; i < SYNC; i++) xhist.push_back(1'b0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        xhist.delete();
        for (int i = 0; i < SYNC; i++) xhist.push_back(1'b0);
        xd_m = 0; meas = 0; cyc = 0; start = 0; hi = 0;
        m_period = 0; m_high = 0; m_mv = 0; m_match = 0; m_locked = 0; m_tmo = 0;
      end else begin
        xs_m   = xhist[0];
        rise_m = xs_m && !xd_m;
        m_mv   = 0;
        if (!bus.en) begin
          meas = 0; m_locked = 0; m_tmo = 0;
        end else if (!meas) begin
          if (rise_m) begin meas = 1; start = cyc; hi = 1; end
        end else if (rise_m) begin
          m_period = cyc - start;
          m_high   = hi;
          m_mv     = 1;
          m_match  = (m_period == EXPP) && (m_high == EXPH);
          m_locked = 1; m_tmo = 0;
          start = cyc; hi = 1;
        end else if (cyc - start == MAXC) begin
          m_tmo = 1; m_locked = 0; meas = 0;
        end else begin
          hi += int'(xs_m);
        end
        xd_m = xs_m;
        void'(xhist.pop_front());
        xhist.push_back(bus.x);
        cyc++;
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      chk("period", int'(bus.period), m_period);
      chk("high_time", int'(bus.high_time), m_high);
      chk("meas_valid", int'(bus.meas_valid), int'(m_mv));
      chk("match", int'(bus.match), int'(m_match));
      chk("locked", int'(bus.locked), int'(m_locked));
      chk("timeout", int'(bus.timeout), int'(m_tmo));
    end
  end
  task automatic tick(input logic xv);
    @(negedge clk);
    mv_seen += int'(bus.meas_valid);
    bus.x = xv;
  endtask
  task automatic pat(input int h, input int l, input int n);
    repeat (n) begin
      repeat (h) tick(1'b1);
      repeat (l) tick(1'b0);
    end
  endtask
  initial begin
    bus.en = 1'b1;
    bus.x  = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("reset_locked", int'(bus.locked), 0);
    pat(1, 4, 8);
    chk("p14_period", int'(bus.period), 5);
    chk("p14_high", int'(bus.high_time), 1);
    chk("p14_match", int'(bus.match), 1);
    chk("p14_locked", int'(bus.locked), 1);
    pat(2, 8, 5);
    chk("p28_period", int'(bus.period), 10);
    chk("p28_high", int'(bus.high_time), 2);
    chk("p28_match", int'(bus.match), 0);
    pat(1, 4, 4);
    chk("back14_period", int'(bus.period), 5);
    chk("back14_match", int'(bus.match), 1);
    pat(1, 1, 6);
    mv_seen = 0;
    pat(1, 1, 5);
    chk("p11_mv_count", mv_seen, 5);
    chk("p11_period", int'(bus.period), 2);
    chk("p11_high", int'(bus.high_time), 1);
    tick(1'b1);
    repeat (24) tick(1'b0);
    chk("to_timeout", int'(bus.timeout), 1);
    chk("to_locked", int'(bus.locked), 0);
    chk("to_period_hold", int'(bus.period), 2);
    pat(1, 4, 4);
    chk("to_clear", int'(bus.timeout), 0);
    chk("to_relock", int'(bus.locked), 1);
    pat(3, 12, 4);
    chk("sat_period", int'(bus.period), 15);
    chk("sat_high", int'(bus.high_time), 3);
    chk("sat_timeout", int'(bus.timeout), 0);
    pat(2, 8, 3);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    bus.en = 1'b0;
    repeat (3) tick(1'b0);
    bus.en = 1'b1;
    tick(1'b0);
    chk("en_locked", int'(bus.locked), 0);
    chk("en_period_hold", int'(bus.period), 10);
    mv_seen = 0;
    pat(1, 4, 1);
    chk("en_one_rise_mv", mv_seen, 0);
    pat(1, 4, 3);
    chk("en_new_period", int'(bus.period), 5);
    pat(1, 4, 3);
    tick(1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_period", int'(bus.period), 0);
    chk("rst_high", int'(bus.high_time), 0);
    chk("rst_mv", int'(bus.meas_valid), 0);
    chk("rst_match", int'(bus.match), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    tick(1'b0);
    tick(1'b0);
    #1 rst_n = 1'b1;
    mv_seen = 0;
    pat(1, 4, 1);
    chk("rst_one_rise_mv", mv_seen, 0);
    pat(1, 4, 2);
    chk("rst_two_rise_mv", int'(mv_seen > 0), 1);
    for (int i = 0; i < 300; i++) begin
      pat($urandom_range(1, 4), $urandom_range(1, 18), $urandom_range(1, 3));
      if ($urandom_range(0, 11) == 0) begin
        bus.en = 1'b0;
        repeat ($urandom_range(1, 4)) tick(bus.x);
        bus.en = 1'b1;
      end
    end
    repeat (5) tick(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
